// File: rtl/ring_pkg.sv
// ring_pkg: shared definitions for the ring counter and its monitor.
//   NUM_BITS : width of the one-hot ring word
//   IDX_W    : width of a binary index into that word
//   state_t  : monitor lock FSM states
//   rotl()   : rotate-left with MSB wrapping into the LSB
//   onehot() : true when exactly one bit is set
package ring_pkg;

  localparam int NUM_BITS = 4;
  localparam int IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  function automatic logic [NUM_BITS-1:0] rotl(input logic [NUM_BITS-1:0] w);
    return {w[NUM_BITS-2:0], w[NUM_BITS-1]};
  endfunction

  // w & (w-1) clears the lowest set bit; zero afterwards means at most one bit.
  function automatic logic onehot(input logic [NUM_BITS-1:0] w);
    return (w != '0) && ((w & (w - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/onehot_to_index.sv
// onehot_to_index: combinational encoder for a ring word.
//   word_i      : candidate one-hot word
//   index_o     : OR of the positions of all set bits (exact when one-hot)
//   is_onehot_o : exactly one bit of word_i is set
module onehot_to_index
  import ring_pkg::*;
(
  input  logic [NUM_BITS-1:0] word_i,
  output logic [IDX_W-1:0]    index_o,
  output logic                is_onehot_o
);

  always_comb begin
    index_o = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (word_i[i]) index_o = index_o | IDX_W'(i);
    end
  end

  assign is_onehot_o = onehot(word_i);

endmodule

// File: rtl/ring_counter_monitor.sv
// ring_counter_monitor: receive-side checker for a one-hot shifting ring
// counter. Samples the ring word each clock, decodes it, tracks sequence
// lock and counts illegal words/transitions.
//   clk_i       : clock, rising edge
//   rst_ni      : async active-low reset
//   ring_i      : one-hot word from the counter
//   load_seen_i : counter load strobe; current word is a legal restart point
//   clear_err_i : synchronous clear of err_count_o (wins over an error)
//   index_o     : position of set bit in last one-hot sample (held otherwise)
//   valid_o     : last sample was one-hot
//   locked_o    : FSM in LOCKED
//   seq_err_o   : one-cycle error pulse
//   err_count_o : saturating error count
module ring_counter_monitor
  import ring_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_BITS-1:0] ring_i,
  input  logic                load_seen_i,
  input  logic                clear_err_i,
  output logic [IDX_W-1:0]    index_o,
  output logic                valid_o,
  output logic                locked_o,
  output logic                seq_err_o,
  output logic [ERR_W-1:0]    err_count_o
);

  localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

  state_t              state_q, state_d;
  logic [GW-1:0]       good_q, good_d;
  logic [NUM_BITS-1:0] prev_q;
  logic [IDX_W-1:0]    index_q;
  logic                valid_q, locked_q, seq_err_q;
  logic [ERR_W-1:0]    err_q, err_d;

  logic [IDX_W-1:0]    dec_idx;
  logic                dec_oh;
  logic                legal, err_evt;

  onehot_to_index u_dec (
    .word_i      (ring_i),
    .index_o     (dec_idx),
    .is_onehot_o (dec_oh)
  );

  // A repeated word is never legal: the counter shifts every clock.
  assign legal = dec_oh && (load_seen_i || (ring_i == rotl(prev_q)));

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_evt = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (dec_oh) begin
          state_d = VERIFY;
          good_d  = '0;
        end
      end
      VERIFY: begin
        if (!legal) begin
          state_d = HUNT;
          err_evt = 1'b1;
        end else if (good_q == GOOD_LAST) begin
          state_d = LOCKED;
        end else begin
          good_d = good_q + 1'b1;
        end
      end
      LOCKED: begin
        if (!legal) begin
          state_d = HUNT;
          err_evt = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (clear_err_i)                  err_d = '0;
    else if (err_evt && (~err_q != '0)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= HUNT;
      good_q    <= '0;
      prev_q    <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      seq_err_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      prev_q    <= ring_i;
      valid_q   <= dec_oh;
      if (dec_oh) index_q <= dec_idx;
      locked_q  <= (state_d == LOCKED);
      seq_err_q <= err_evt;
      err_q     <= err_d;
    end
  end

  assign index_o     = index_q;
  assign valid_o     = valid_q;
  assign locked_o    = locked_q;
  assign seq_err_o   = seq_err_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_ring_counter_monitor.sv
module tb_ring_counter_monitor;
  import ring_pkg::*;

  localparam int LK = 4;
  localparam int EW = 8;
  localparam int EMAX = (1 << EW) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_BITS-1:0] ring = '0;
  logic                ld = 1'b0, clr = 1'b0;
  logic [IDX_W-1:0]    index;
  logic                valid, locked, seq_err;
  logic [EW-1:0]       err_count;

  ring_counter_monitor #(.LOCK_CNT(LK), .ERR_W(EW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ring_i(ring), .load_seen_i(ld),
    .clear_err_i(clr), .index_o(index), .valid_o(valid), .locked_o(locked),
    .seq_err_o(seq_err), .err_count_o(err_count)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "tracking" = a one-hot word has been seen since the
  // last error/reset; "run" = legal transitions since tracking began.
  bit m_track;
  int m_run, m_prev, m_idx, m_cnt;
  bit m_valid, m_locked, m_err;

  function automatic bit is_oh(input int w);
    return $countones(w[NUM_BITS-1:0]) == 1 && w < (1 << NUM_BITS);
  endfunction

  function automatic int pos(input int w);
    return $clog2(w);
  endfunction

  task automatic model_reset();
    m_track = 0; m_run = 0; m_prev = 0; m_idx = 0; m_cnt = 0;
    m_valid = 0; m_locked = 0; m_err = 0;
  endtask

  task automatic model_step(input int w, input bit l, input bit c);
    bit oh, lg;
    oh = is_oh(w);
    lg = oh && (l || (is_oh(m_prev) && pos(w) == (pos(m_prev) + 1) % NUM_BITS));
    m_err = 0;
    if (!m_track) begin
      if (oh) begin m_track = 1; m_run = 0; end
    end else if (lg) m_run++;
    else begin m_track = 0; m_run = 0; m_err = 1; end
    m_locked = m_track && (m_run >= LK);
    m_valid = oh;
    if (oh) m_idx = pos(w);
    if (c) m_cnt = 0;
    else if (m_err && m_cnt < EMAX) m_cnt++;
    m_prev = w;
  endtask

  task automatic apply(input int w, input bit l, input bit c);
    ring = w[NUM_BITS-1:0]; ld = l; clr = c;
    @(posedge clk); #1;
    model_step(w, l, c);
    chk("m_valid", valid, m_valid);
    chk("m_index", index, m_idx);
    chk("m_locked", locked, m_locked);
    chk("m_seq_err", seq_err, m_err);
    chk("m_err_count", err_count, m_cnt);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_index"}, index, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_seq_err"}, seq_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  typedef struct {
    int w; bit l; bit c;
    bit ev; int ei; bit el; bit es; int ec;
  } vec_t;

  vec_t vt[22];
  int   r;

  initial begin
    vt = '{
      '{1, 0, 0, 1, 0, 0, 0, 0},  // lock acquisition
      '{2, 0, 0, 1, 1, 0, 0, 0},
      '{4, 0, 0, 1, 2, 0, 0, 0},
      '{8, 0, 0, 1, 3, 0, 0, 0},
      '{1, 0, 0, 1, 0, 1, 0, 0},  // fifth word -> locked
      '{2, 0, 0, 1, 1, 1, 0, 0},
      '{4, 0, 0, 1, 2, 1, 0, 0},
      '{4, 0, 0, 1, 2, 0, 1, 1},  // held word: error, lock lost
      '{8, 0, 0, 1, 3, 0, 0, 1},  // HUNT -> VERIFY
      '{1, 0, 0, 1, 0, 0, 0, 1},
      '{2, 0, 0, 1, 1, 0, 0, 1},
      '{4, 0, 0, 1, 2, 0, 0, 1},
      '{8, 0, 0, 1, 3, 1, 0, 1},  // re-locked
      '{1, 0, 0, 1, 0, 1, 0, 1},
      '{2, 0, 0, 1, 1, 1, 0, 1},
      '{8, 1, 0, 1, 3, 1, 0, 1},  // load restart point, no error
      '{1, 0, 0, 1, 0, 1, 0, 1},
      '{6, 0, 0, 0, 0, 0, 1, 2},  // multi-bit: error, index held
      '{0, 0, 0, 0, 0, 0, 0, 2},  // zero in HUNT: no error
      '{2, 0, 0, 1, 1, 0, 0, 2},
      '{2, 0, 0, 1, 1, 0, 1, 3},  // hold in VERIFY
      '{1, 0, 1, 1, 0, 0, 0, 0}   // clear
    };

    model_reset();
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    @(negedge clk) rst_n = 1'b1;

    foreach (vt[k]) begin
      apply(vt[k].w, vt[k].l, vt[k].c);
      chk($sformatf("v%0d_valid", k), valid, vt[k].ev);
      chk($sformatf("v%0d_index", k), index, vt[k].ei);
      chk($sformatf("v%0d_locked", k), locked, vt[k].el);
      chk($sformatf("v%0d_seq_err", k), seq_err, vt[k].es);
      chk($sformatf("v%0d_err_count", k), err_count, vt[k].ec);
    end

    // Saturation: each (one-hot, zero) pair yields exactly one error.
    for (int i = 0; i < 300; i++) begin
      apply(1, 0, 0);
      apply(0, 0, 0);
    end
    chk("sat_count", err_count, EMAX);
    apply(1, 0, 0);
    apply(0, 0, 1);  // error and clear together
    chk("clr_seq_err", seq_err, 1);
    chk("clr_count", err_count, 0);

    // Async reset mid-lock.
    apply(1, 0, 0); apply(2, 0, 0); apply(4, 0, 0); apply(8, 0, 0); apply(1, 0, 0);
    chk("pre_rst_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk); #3 rst_n = 1'b1;
    model_reset();
    apply(2, 0, 0);
    chk("post_rst_seq_err", seq_err, 0);
    apply(4, 0, 0); apply(8, 0, 0); apply(1, 0, 0); apply(2, 0, 0);
    chk("relock", locked, 1);

    // Randomized traffic against the model.
    r = 1;
    for (int i = 0; i < 600; i++) begin
      int sel;
      bit l, c;
      sel = $urandom_range(0, 99);
      l = 0;
      c = ($urandom_range(0, 99) < 3);
      if (sel < 75) r = is_oh(r) ? (1 << ((pos(r) + 1) % NUM_BITS)) : 1;
      else if (sel < 85) begin r = 1 << $urandom_range(0, NUM_BITS - 1); l = 1; end
      else r = $urandom_range(0, (1 << NUM_BITS) - 1);
      apply(r, l, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
